// File: rtl/bmem_line_adapter.sv
// Adapts 256-bit cache line fills/writebacks onto a 64-bit, 4-beat burst memory port.
// Optional perf counters are enabled with BMEM_LINE_ADAPTER_PERF_EN.
module bmem_line_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_addr,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  bmem_address,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_resp
`ifdef BMEM_LINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]  perf_fill_count,
  output logic [31:0]  perf_wb_count
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   line_rdata_q, line_rdata_d;
  logic           line_resp_q, line_resp_d;
  logic [31:0]    bmem_address_q, bmem_address_d;
  logic           bmem_read_q, bmem_read_d;
  logic           bmem_write_q, bmem_write_d;
  logic [63:0]    bmem_wdata_q, bmem_wdata_d;
  logic           addr_lsb_unused;

  assign addr_lsb_unused = ^line_addr[4:0];

  // Next-state, beat counter, latched request and fill assembly.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    line_rdata_d = line_rdata_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          addr_d  = {line_addr[31:5], 5'b00000};
          wdata_d = line_wdata;
          cnt_d   = 2'd0;
          state_d = WR_BURST;
        end else if (line_read) begin
          addr_d  = {line_addr[31:5], 5'b00000};
          cnt_d   = 2'd0;
          state_d = RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        state_d = RD_BURST;
      end
      RD_BURST: begin
        if (bmem_resp) begin
          line_rdata_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = WR_BURST;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered, so decode them from the upcoming state.
  always_comb begin
    bmem_read_d    = (state_d == RD_REQ);
    bmem_write_d   = (state_d == WR_BURST);
    line_resp_d    = (state_d == DONE);
    bmem_address_d = 32'd0;
    bmem_wdata_d   = 64'd0;
    if (state_d != IDLE) begin
      bmem_address_d = addr_d;
    end else begin
      bmem_address_d = 32'd0;
    end
    if (state_d == WR_BURST) begin
      bmem_wdata_d = wdata_d[{cnt_d, 6'd0} +: 64];
    end else begin
      bmem_wdata_d = 64'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 2'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 256'd0;
      line_rdata_q   <= 256'd0;
      line_resp_q    <= 1'b0;
      bmem_address_q <= 32'd0;
      bmem_read_q    <= 1'b0;
      bmem_write_q   <= 1'b0;
      bmem_wdata_q   <= 64'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      line_rdata_q   <= line_rdata_d;
      line_resp_q    <= line_resp_d;
      bmem_address_q <= bmem_address_d;
      bmem_read_q    <= bmem_read_d;
      bmem_write_q   <= bmem_write_d;
      bmem_wdata_q   <= bmem_wdata_d;
    end
  end

  assign line_rdata   = line_rdata_q;
  assign line_resp    = line_resp_q;
  assign bmem_address = bmem_address_q;
  assign bmem_read    = bmem_read_q;
  assign bmem_write   = bmem_write_q;
  assign bmem_wdata   = bmem_wdata_q;

`ifdef BMEM_LINE_ADAPTER_PERF_EN
  logic        op_wr_q, op_wr_d;
  logic [31:0] perf_fill_q, perf_fill_d;
  logic [31:0] perf_wb_q, perf_wb_d;

  // Remember the accepted request type so completion can be attributed.
  always_comb begin
    op_wr_d     = op_wr_q;
    perf_fill_d = perf_fill_q;
    perf_wb_d   = perf_wb_q;
    if (state_q == IDLE && line_write) begin
      op_wr_d = 1'b1;
    end else if (state_q == IDLE && line_read) begin
      op_wr_d = 1'b0;
    end else begin
      op_wr_d = op_wr_q;
    end
    if (line_resp_q) begin
      if (op_wr_q) begin
        perf_wb_d = perf_wb_q + 32'd1;
      end else begin
        perf_fill_d = perf_fill_q + 32'd1;
      end
    end else begin
      perf_fill_d = perf_fill_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q     <= 1'b0;
      perf_fill_q <= 32'd0;
      perf_wb_q   <= 32'd0;
    end else begin
      op_wr_q     <= op_wr_d;
      perf_fill_q <= perf_fill_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_fill_count = perf_fill_q;
  assign perf_wb_count   = perf_wb_q;
`endif

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Self-checking bench for bmem_line_adapter: directed and randomized line transfers
// checked cycle by cycle against expectations derived from transaction-level rules.
module tb_bmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_addr;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata;
  logic         bmem_resp;
`ifdef BMEM_LINE_ADAPTER_PERF_EN
  logic [31:0]  perf_fill_count;
  logic [31:0]  perf_wb_count;
`endif

  always #5 clk = ~clk;

  bmem_line_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_addr    (line_addr),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp)
`ifdef BMEM_LINE_ADAPTER_PERF_EN
    ,
    .perf_fill_count (perf_fill_count),
    .perf_wb_count   (perf_wb_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_fills = 0;
  int exp_wbs   = 0;
  logic [255:0] last_fill = 256'd0;
  logic [63:0]  rb [4];
  int           rc [4];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_bmem_read"}, {255'd0, bmem_read}, 256'd0);
    chk({tag, "_bmem_write"}, {255'd0, bmem_write}, 256'd0);
    chk({tag, "_line_resp"}, {255'd0, line_resp}, 256'd0);
    chk({tag, "_bmem_address"}, {224'd0, bmem_address}, 256'd0);
    chk({tag, "_bmem_wdata"}, {192'd0, bmem_wdata}, 256'd0);
  endtask

  // Fill using beats rb[0..3] presented in absolute cycles rc[0..3] (cycle 0 = request).
  task automatic run_read(input logic [31:0] addr);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    int k;
    int last;
    exp_line = {rb[3], rb[2], rb[1], rb[0]};
    exp_addr = {addr[31:5], 5'b00000};
    k = 0;
    last = rc[3] + 1;
    @(posedge clk); #1;
    line_read = 1'b1; line_write = 1'b0; line_addr = addr; bmem_resp = 1'b0;
    @(negedge clk);
    chk_quiet("rd_c0");
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (k < 4 && c == rc[k]) begin
        bmem_resp = 1'b1; bmem_rdata = rb[k]; k++;
      end else begin
        bmem_resp = 1'b0; bmem_rdata = rand64();
      end
      if (c == last) begin
        line_read = 1'b0; line_addr = $urandom();
      end
      @(negedge clk);
      chk("rd_bmem_read", {255'd0, bmem_read}, {255'd0, (c == 1)});
      chk("rd_bmem_address", {224'd0, bmem_address}, {224'd0, exp_addr});
      chk("rd_bmem_write", {255'd0, bmem_write}, 256'd0);
      chk("rd_bmem_wdata", {192'd0, bmem_wdata}, 256'd0);
      chk("rd_line_resp", {255'd0, line_resp}, {255'd0, (c == last)});
    end
    chk("rd_line_rdata", line_rdata, exp_line);
    bmem_resp = 1'b0;
    last_fill = exp_line;
    exp_fills++;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] data, input logic also_read);
    logic [31:0] exp_addr;
    logic [63:0] exp_w;
    exp_addr = {addr[31:5], 5'b00000};
    @(posedge clk); #1;
    line_write = 1'b1; line_read = also_read; line_addr = addr; line_wdata = data;
    @(negedge clk);
    chk_quiet("wr_c0");
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bmem_resp  = $urandom_range(0, 1) == 1;
      bmem_rdata = rand64();
      if (c == 1) line_wdata = {rand64(), rand64(), rand64(), rand64()};
      if (c == 5) begin
        line_write = 1'b0; line_read = 1'b0;
      end
      @(negedge clk);
      exp_w = (c <= 4) ? data[64*(c-1) +: 64] : 64'd0;
      chk("wr_bmem_write", {255'd0, bmem_write}, {255'd0, (c <= 4)});
      chk("wr_bmem_wdata", {192'd0, bmem_wdata}, {192'd0, exp_w});
      chk("wr_bmem_read", {255'd0, bmem_read}, 256'd0);
      chk("wr_bmem_address", {224'd0, bmem_address}, {224'd0, exp_addr});
      chk("wr_line_resp", {255'd0, line_resp}, {255'd0, (c == 5)});
      chk("wr_line_rdata_stable", line_rdata, last_fill);
    end
    bmem_resp = 1'b0;
    exp_wbs++;
  endtask

  task automatic check_perf();
    @(posedge clk); #1;
    @(negedge clk);
`ifdef BMEM_LINE_ADAPTER_PERF_EN
    chk("perf_fill_count", {224'd0, perf_fill_count}, {224'd0, 32'(exp_fills)});
    chk("perf_wb_count", {224'd0, perf_wb_count}, {224'd0, 32'(exp_wbs)});
`else
    chk_quiet("idle_gap");
`endif
  endtask

  task automatic rand_gaps();
    rc[0] = 2 + int'($urandom_range(0, 2));
    for (int i = 1; i < 4; i++) rc[i] = rc[i-1] + 1 + int'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; line_addr = 32'd0; line_read = 1'b0; line_write = 1'b0;
    line_wdata = 256'd0; bmem_rdata = 64'd0; bmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_line_rdata", line_rdata, 256'd0);
    #1 rst = 1'b0;

    // Back-to-back read beats.
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    rc[0] = 2; rc[1] = 3; rc[2] = 4; rc[3] = 5;
    run_read(32'h0000_1234);
    chk("fill_addr_1220_seen", {224'd0, 32'h0000_1234 & 32'hFFFF_FFE0}, {224'd0, 32'h0000_1220});

    // Spurious memory responses while idle must change nothing.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bmem_resp = 1'b1; bmem_rdata = rand64();
      @(negedge clk);
      chk_quiet("idle_spurious");
      chk("idle_spurious_rdata", line_rdata, last_fill);
    end
    @(posedge clk); #1 bmem_resp = 1'b0;

    run_write(32'h8000_0040,
              256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A55A5A5A5A_0123456789ABCDEF, 1'b0);

    // Gapped beats at cycles 3, 6, 7, 12.
    for (int i = 0; i < 4; i++) rb[i] = rand64();
    rc[0] = 3; rc[1] = 6; rc[2] = 7; rc[3] = 12;
    run_read(32'hDEAD_BEEF);

    // Simultaneous read and write requests: write wins.
    run_write($urandom(), {rand64(), rand64(), rand64(), rand64()}, 1'b1);
    check_perf();

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) rb[i] = rand64();
        rand_gaps();
        run_read($urandom());
      end else begin
        run_write($urandom(), {rand64(), rand64(), rand64(), rand64()},
                  $urandom_range(0, 1) == 1);
      end
    end
    check_perf();

    // Reset in the middle of a fill, after two beats.
    @(posedge clk); #1;
    line_read = 1'b1; line_addr = $urandom();
    @(posedge clk); #1;
    @(posedge clk); #1 bmem_resp = 1'b1; bmem_rdata = rand64();
    @(posedge clk); #1 bmem_resp = 1'b1; bmem_rdata = rand64();
    @(posedge clk); #1 rst = 1'b1; line_read = 1'b0; bmem_resp = 1'b1; bmem_rdata = rand64();
    exp_fills = 0; exp_wbs = 0; last_fill = 256'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; bmem_resp = 1'b1; bmem_rdata = rand64();
      @(negedge clk);
      chk_quiet("post_reset");
      chk("post_reset_rdata", line_rdata, 256'd0);
    end
    @(posedge clk); #1 bmem_resp = 1'b0;

    for (int i = 0; i < 4; i++) rb[i] = rand64();
    rand_gaps();
    run_read($urandom());
    check_perf();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bmem_line_adapter.md
BMEM_LINE_ADAPTER -- requirements
Module: bmem_line_adapter

Interface
REQ-001 The port `clk` SHALL be an input, 1 bit wide, and be the single clock; all logic is rising-edge triggered.
REQ-002 The port `rst` SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-003 The port `line_addr` SHALL be an input, 32 bits wide, and carry the cacheline byte address from the cache; bits [4:0] are ignored.
REQ-004 The port `line_read` SHALL be an input, 1 bit wide, and request a 256-bit line fill; it is held until `line_resp`.
REQ-005 The port `line_write` SHALL be an input, 1 bit wide, and request a 256-bit line writeback; it is held until `line_resp`.
REQ-006 The port `line_wdata` SHALL be an input, 256 bits wide, and carry the writeback line data.
REQ-007 The port `line_rdata` SHALL be an output, 256 bits wide, and carry the assembled fill data, valid when `line_resp`=1.
REQ-008 The port `line_resp` SHALL be an output, 1 bit wide, and pulse for 1 cycle when the request is complete.
REQ-009 The port `bmem_address` SHALL be an output, 32 bits wide, and carry the 32-byte-aligned burst address.
REQ-010 The port `bmem_read` SHALL be an output, 1 bit wide, and be a one-cycle read request pulse.
REQ-011 The port `bmem_write` SHALL be an output, 1 bit wide, and be high for each write beat.
REQ-012 The port `bmem_wdata` SHALL be an output, 64 bits wide, and carry the current write beat.
REQ-013 The port `bmem_rdata` SHALL be an input, 64 bits wide, and carry a read beat, valid when `bmem_resp`=1.
REQ-014 The port `bmem_resp` SHALL be an input, 1 bit wide, and mark a valid read beat.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RD_REQ, RD_BURST, WR_BURST and DONE.
REQ-016 In IDLE, when `line_write`=1, the block SHALL latch {`line_addr`[31:5], 5'b0} and `line_wdata`, then go to WR_BURST; writes take priority when both requests are high.
REQ-017 In IDLE, when `line_read`=1 and `line_write`=0, the block SHALL latch the aligned address and go to RD_REQ.
REQ-018 RD_REQ SHALL drive `bmem_read`=1 for exactly 1 cycle with the latched address, then go to RD_BURST.
REQ-019 In RD_BURST, each cycle with `bmem_resp`=1 SHALL store `bmem_rdata` into line slice [64*k+63:64*k].
  - The 2-bit beat counter k starts at 0.
  - Beat 0 is the least-significant slice.
  - The beat counter wraps 3->0.
REQ-020 RD_BURST SHALL wait indefinitely on cycles with `bmem_resp`=0 (gaps between beats allowed), and go to DONE after the 4th beat.
REQ-021 WR_BURST SHALL drive `bmem_write`=1 for 4 consecutive cycles, with `bmem_wdata` = latched slice k, k=0..3, and address held; it then goes to DONE.
REQ-022 DONE SHALL assert `line_resp`=1 for 1 cycle and return to IDLE.
  - `line_rdata` stays stable until the next fill begins.
  - A new request is accepted no earlier than the cycle after DONE.
REQ-023 Latency SHALL be as follows.
  - Read: request accepted in cycle 0, `bmem_read` in cycle 1, `line_resp` in the cycle after the 4th beat.
  - Write: `bmem_write` in cycles 1-4, `line_resp` in cycle 5.
REQ-024 `bmem_resp` SHALL be ignored outside RD_BURST, and a 5th beat SHALL never be stored.
REQ-025 `bmem_read`, `bmem_write` and `line_resp` SHALL never be high simultaneously.
REQ-026 `bmem_address` SHALL hold the latched value in all non-IDLE states, and SHALL be 0 in IDLE.
REQ-027 `bmem_wdata` SHALL be 0 whenever `bmem_write`=0.

Reset
REQ-028 When `rst`=1 at a clock edge, the block SHALL take the reset values.
  - State is IDLE; beat counter, latched address, latched wdata and `line_rdata` are 0.
  - `line_resp`, `bmem_read` and `bmem_write` are 0.
REQ-029 Reset mid-burst SHALL abort the transfer without asserting `line_resp`; beats arriving after reset are ignored.

Configuration
REQ-030 With BMEM_LINE_ADAPTER_PERF_EN defined, the block SHALL add the following outputs.
  - `perf_fill_count` and `perf_wb_count` are 32-bit counters that increment on each `line_resp` for a read or write respectively.
  - Both reset to 0 and wrap at 2^32.
REQ-031 Without BMEM_LINE_ADAPTER_PERF_EN, those ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-032 Read with `line_addr`=0x0000_1234 and beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> `bmem_address`=0x0000_1220 with a 1-cycle `bmem_read`; `line_rdata`={0x44..,0x33..,0x22..,0x11..}; `line_resp` appears 1 cycle after the 4th beat.
REQ-033 Write with `line_addr`=0x8000_0040 and `line_wdata`=256'h0123...CDEF -> `bmem_write` high for exactly 4 cycles with slices 0..3 in order, address 0x8000_0040; `line_resp` appears in cycle 5.
REQ-034 Read with beats at cycles 3, 6, 7, 12 (gapped) -> all 4 slices are correct and `line_resp` appears at cycle 13; a spurious `bmem_resp` in IDLE changes nothing.
REQ-035 `line_read`=`line_write`=1 simultaneously -> the writeback is performed, with no `bmem_read`.
REQ-036 `rst` asserted after beat 2 of a read -> outputs are 0 the next cycle, with no `line_resp`; a following read completes correctly.
REQ-037 With PERF_EN defined, after 3 fills and 2 writebacks -> `perf_fill_count`=3 and `perf_wb_count`=2.
